wb_cmd_master: RTL and testbench

- Wishbone classic single-transfer master; sits directly upstream of the simulation top's `s_wb_*` slave port.
- Converts a valid/ready command stream (read/write, address, data, byte-select) into one Wishbone cycle at a time.
- Returns each result (read data, or write completion) on a valid/ready response stream.
- Lets the register-access test driver be pure RTL with no time waits, so it runs under both Verilator and event simulators.

---
 rtl/wb_cmd_master_pkg.sv | 28 ++
 rtl/wb_cmd_master_timer.sv | 31 +++
 rtl/wb_cmd_master.sv | 121 ++++++++++++
 tb/tb_wb_cmd_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_master_pkg.sv
// Shared types for the Wishbone command master: FSM state and the command/response records.
// Struct widths track the default Wishbone geometry (37-bit address, 64-bit data).
package wb_cmd_master_pkg;

  localparam int ADR_W = 37;
  localparam int DAT_W = 64;
  localparam int SEL_W = DAT_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
  } cmd_t;

  typedef struct packed {
    logic [DAT_W-1:0] dat;
    logic             we;
    logic             err;
  } rsp_t;

endpackage

// File: rtl/wb_cmd_master_timer.sv
// Bus-wait counter for the optional abort path (built only with WB_CMD_MASTER_TIMEOUT_EN).
// expired is high once TIMEOUT_CYCLES-1 stalled cycles have been counted since the last clear.
module wb_cmd_master_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Saturates at LAST so a stuck enable can never wrap back to a non-expired value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master driven by a valid/ready command stream.
// Define WB_CMD_MASTER_TIMEOUT_EN to abort stalled bus cycles with an error response.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int WB_ADR_WIDTH   = 37,
  parameter int WB_DAT_WIDTH   = 64,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic [WB_ADR_WIDTH-1:0] s_cmd_adr,
  input  logic [WB_DAT_WIDTH-1:0] s_cmd_dat,
  input  logic [WB_SEL_WIDTH-1:0] s_cmd_sel,
  input  logic                    s_cmd_we,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  output logic [WB_DAT_WIDTH-1:0] m_rsp_dat,
  output logic                    m_rsp_we,
  output logic                    m_rsp_err,
  output logic                    m_rsp_valid,
  input  logic                    m_rsp_ready,
  output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
  input  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i,
  output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
  output logic                    m_wb_we_o,
  output logic                    m_wb_stb_o,
  input  logic                    m_wb_ack_i,
  output logic                    busy,
  output logic [COUNT_WIDTH-1:0]  count
);

  state_t state_reg;
  logic   cmd_fire;
  logic   ack_hit;
  logic   timeout_hit;

  assign cmd_fire = s_cmd_valid && (state_reg == IDLE);
  // An ack only counts while our strobe is up; stray acks are ignored everywhere.
  assign ack_hit  = (state_reg == BUS) && m_wb_stb_o && m_wb_ack_i;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic timer_expired;

  wb_cmd_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (cmd_fire),
    .enable ((state_reg == BUS) && !ack_hit),
    .expired(timer_expired)
  );

  assign timeout_hit = (state_reg == BUS) && timer_expired && !ack_hit;
`else
  // No abort path in this build: the bus waits for ack indefinitely.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign s_cmd_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      m_wb_adr_o  <= '0;
      m_wb_dat_o  <= '0;
      m_wb_sel_o  <= '0;
      m_wb_we_o   <= 1'b0;
      m_wb_stb_o  <= 1'b0;
      m_rsp_dat   <= '0;
      m_rsp_we    <= 1'b0;
      m_rsp_err   <= 1'b0;
      m_rsp_valid <= 1'b0;
      count       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            m_wb_adr_o <= s_cmd_adr;
            m_wb_dat_o <= s_cmd_dat;
            m_wb_sel_o <= s_cmd_sel;
            m_wb_we_o  <= s_cmd_we;
            m_wb_stb_o <= 1'b1;
            state_reg  <= BUS;
          end
        end
        BUS: begin
          if (ack_hit) begin
            m_wb_stb_o  <= 1'b0;
            m_rsp_dat   <= m_wb_we_o ? '0 : m_wb_dat_i;
            m_rsp_we    <= m_wb_we_o;
            m_rsp_err   <= 1'b0;
            m_rsp_valid <= 1'b1;
            state_reg   <= RESP;
          end else if (timeout_hit) begin
            m_wb_stb_o  <= 1'b0;
            m_rsp_dat   <= '0;
            m_rsp_we    <= m_wb_we_o;
            m_rsp_err   <= 1'b1;
            m_rsp_valid <= 1'b1;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (m_rsp_ready) begin
            m_rsp_valid <= 1'b0;
            count       <= count + 1'b1;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: transaction-level reference model plus directed and random traffic.
// Build with WB_CMD_MASTER_TIMEOUT_EN to also exercise the abort path (TIMEOUT_CYCLES = 8).
`timescale 1ns/1ps
module tb_wb_cmd_master;
  import wb_cmd_master_pkg::*;

  localparam int TMO   = 8;
  localparam int LIMIT = 200;
  localparam logic [63:0] B2B_BASE = 64'hA5A5_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [36:0] s_cmd_adr = '0;
  logic [63:0] s_cmd_dat = '0;
  logic [7:0]  s_cmd_sel = '0;
  logic        s_cmd_we = 1'b0;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [63:0] m_rsp_dat;
  logic        m_rsp_we, m_rsp_err, m_rsp_valid, m_rsp_ready;
  logic [36:0] m_wb_adr_o;
  logic [63:0] m_wb_dat_o;
  logic [63:0] m_wb_dat_i = '0;
  logic [7:0]  m_wb_sel_o;
  logic        m_wb_we_o, m_wb_stb_o;
  logic        m_wb_ack_i = 1'b0;
  logic        busy;
  logic [31:0] count;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .reset(reset), .clk(clk),
    .s_cmd_adr(s_cmd_adr), .s_cmd_dat(s_cmd_dat), .s_cmd_sel(s_cmd_sel),
    .s_cmd_we(s_cmd_we), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .m_rsp_dat(m_rsp_dat), .m_rsp_we(m_rsp_we), .m_rsp_err(m_rsp_err),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_ack_i(m_wb_ack_i), .busy(busy), .count(count)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Reference model: one transfer in flight, tracked as "on the bus" or "response pending".
  bit          bus_active = 1'b0;
  bit          rsp_pending = 1'b0;
  bit          fresh = 1'b1;
  logic [36:0] cur_adr = '0;
  logic [63:0] cur_dat = '0;
  logic [7:0]  cur_sel = '0;
  logic        cur_we = 1'b0;
  int          bus_waits = 0;
  rsp_t        exp_rsp = '0;
  logic [31:0] count_exp = '0;
  int          cyc = 0;
  rsp_t        rsp_log[$];
  int          accept_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      bus_active  = 1'b0;
      rsp_pending = 1'b0;
      fresh       = 1'b1;
      count_exp   = '0;
    end else if (rsp_pending) begin
      if (m_rsp_ready) begin
        rsp_pending = 1'b0;
        count_exp   = count_exp + 1;
        rsp_log.push_back(exp_rsp);
        $display("rsp %0d: we=%0b err=%0b dat=%h count=%0d", rsp_log.size(), exp_rsp.we,
                 exp_rsp.err, exp_rsp.dat, count_exp);
      end
    end else if (bus_active) begin
      if (m_wb_ack_i) begin
        exp_rsp.dat = cur_we ? 64'h0 : m_wb_dat_i;
        exp_rsp.we  = cur_we;
        exp_rsp.err = 1'b0;
        bus_active  = 1'b0;
        rsp_pending = 1'b1;
      end else begin
        bus_waits++;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        if (bus_waits == TMO) begin
          exp_rsp.dat = 64'h0;
          exp_rsp.we  = cur_we;
          exp_rsp.err = 1'b1;
          bus_active  = 1'b0;
          rsp_pending = 1'b1;
        end
`endif
      end
    end else if (s_cmd_valid) begin
      cur_adr    = s_cmd_adr;
      cur_dat    = s_cmd_dat;
      cur_sel    = s_cmd_sel;
      cur_we     = s_cmd_we;
      bus_waits  = 0;
      bus_active = 1'b1;
      fresh      = 1'b0;
      accept_cyc.push_back(cyc);
    end
  end

  // Compare process: every cycle once out of the initial reset.
  logic [63:0] dut_dat;
  logic        dut_we, dut_err;
  logic [36:0] dut_wb_adr;
  logic [63:0] dut_wb_dat;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", s_cmd_ready, !bus_active && !rsp_pending);
      chk("busy", busy, bus_active || rsp_pending);
      chk("stb", m_wb_stb_o, bus_active);
      chk("rsp_valid", m_rsp_valid, rsp_pending);
      chk("count", count, count_exp);
      if (bus_active) begin
        chk("wb_adr", m_wb_adr_o, cur_adr);
        chk("wb_dat", m_wb_dat_o, cur_dat);
        chk("wb_sel", m_wb_sel_o, cur_sel);
        chk("wb_we", m_wb_we_o, cur_we);
        dut_wb_adr = m_wb_adr_o;
        dut_wb_dat = m_wb_dat_o;
      end
      if (rsp_pending) begin
        chk("rsp_dat", m_rsp_dat, exp_rsp.dat);
        chk("rsp_we", m_rsp_we, exp_rsp.we);
        chk("rsp_err", m_rsp_err, exp_rsp.err);
        dut_dat = m_rsp_dat;
        dut_we  = m_rsp_we;
        dut_err = m_rsp_err;
      end
      if (fresh && !bus_active && !rsp_pending) begin
        chk("rst_wb_adr", m_wb_adr_o, 0);
        chk("rst_wb_dat", m_wb_dat_o, 0);
        chk("rst_wb_sel", m_wb_sel_o, 0);
        chk("rst_wb_we", m_wb_we_o, 0);
        chk("rst_rsp_dat", m_rsp_dat, 0);
        chk("rst_rsp_we", m_rsp_we, 0);
        chk("rst_rsp_err", m_rsp_err, 0);
      end
    end
  end

  // Slave model: ack after ack_wait stb cycles (-1 never, -2 random per transfer).
  int          ack_wait = 0;
  int          cur_wait = 0;
  int          stb_cycles = 0;
  int          last_stb_len = 0;
  bit          spurious = 1'b0;
  int          dat_mode = 0;
  logic [63:0] rd_fixed = '0;
  bit          rand_rdy = 1'b0;
  bit          rdy_fixed = 1'b0;
  bit          rdy_rand_bit = 1'b0;

  assign m_rsp_ready = rand_rdy ? rdy_rand_bit : rdy_fixed;

  always @(negedge clk) begin
    rdy_rand_bit = ($urandom_range(0, 2) != 0);
    if (m_wb_stb_o === 1'b1) begin
      if (stb_cycles == 0) begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cur_wait = (ack_wait == -2) ? int'($urandom_range(0, 10)) : ack_wait;
`else
        cur_wait = (ack_wait == -2) ? int'($urandom_range(0, 3)) : ack_wait;
`endif
      end
      m_wb_ack_i = (cur_wait >= 0) && (stb_cycles == cur_wait);
      stb_cycles++;
    end else begin
      if (stb_cycles != 0) last_stb_len = stb_cycles;
      stb_cycles = 0;
      m_wb_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    case (dat_mode)
      1:       m_wb_dat_i = rd_fixed;
      2:       m_wb_dat_i = B2B_BASE | 64'(m_wb_adr_o);
      default: m_wb_dat_i = {$urandom, $urandom};
    endcase
  end

  task automatic issue(input logic we, input logic [36:0] adr, input logic [63:0] dat,
                       input logic [7:0] sel);
    int k = 0;
    s_cmd_we    = we;
    s_cmd_adr   = adr;
    s_cmd_dat   = dat;
    s_cmd_sel   = sel;
    s_cmd_valid = 1'b1;
    while (s_cmd_ready !== 1'b1 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    if (k >= LIMIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: got no ready after %0d cycles, required ready", k);
    end
    @(negedge clk);
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int limit);
    int k = 0;
    while (rsp_log.size() < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_arrived", rsp_log.size() >= n, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nr;
    int k;
    int ab;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset_ready", s_cmd_ready, 1);
    chk("reset_count", count, 0);
    chk("reset_stb", m_wb_stb_o, 0);

    // Write, ack in the first strobe cycle.
    rdy_fixed = 1'b1;
    ack_wait  = 0;
    issue(1'b1, 37'h10, 64'h1122334455667788, 8'hFF);
    wait_rsp(1, LIMIT);
    chk("t1_wb_adr", dut_wb_adr, 64'h10);
    chk("t1_wb_dat", dut_wb_dat, 64'h1122334455667788);
    chk("t1_rsp_we", dut_we, 1);
    chk("t1_rsp_dat", dut_dat, 0);
    chk("t1_rsp_err", dut_err, 0);
    chk("t1_stb_len", last_stb_len, 1);
    chk("t1_count", count, 1);

    // Read with five wait states.
    ack_wait = 5;
    dat_mode = 1;
    rd_fixed = 64'hDEADBEEF_CAFEF00D;
    issue(1'b0, 37'h20, 64'h0, 8'hFF);
    wait_rsp(2, LIMIT);
    chk("t2_rsp_dat", dut_dat, 64'hDEADBEEFCAFEF00D);
    chk("t2_rsp_we", dut_we, 0);
    chk("t2_stb_len", last_stb_len, 6);
    chk("t2_count", count, 2);

    // Response back-pressure with a second command waiting.
    ack_wait  = 0;
    dat_mode  = 0;
    rdy_fixed = 1'b0;
    issue(1'b1, 37'h30, 64'h0123456789ABCDEF, 8'h0F);
    k = 0;
    while (m_rsp_valid !== 1'b1 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    s_cmd_we    = 1'b0;
    s_cmd_adr   = 37'h38;
    s_cmd_dat   = 64'h0;
    s_cmd_sel   = 8'hF0;
    s_cmd_valid = 1'b1;
    repeat (4) begin
      chk("bp_ready", s_cmd_ready, 0);
      chk("bp_rsp_valid", m_rsp_valid, 1);
      @(negedge clk);
    end
    rdy_fixed = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", s_cmd_ready, 1);
    chk("bp_stb_after", m_wb_stb_o, 0);
    @(negedge clk);
    s_cmd_valid = 1'b0;
    chk("bp_accept_stb", m_wb_stb_o, 1);
    chk("bp_accept_adr", m_wb_adr_o, 64'h38);
    wait_rsp(4, LIMIT);
    chk("bp_count", count, 4);

    // Stray acks while idle, then reset in the middle of a bus cycle.
    spurious = 1'b1;
    repeat (6) @(negedge clk);
    chk("spur_stb", m_wb_stb_o, 0);
    chk("spur_rsp", m_rsp_valid, 0);
    spurious = 1'b0;
    ack_wait = -1;
    issue(1'b0, 37'h40, 64'h0, 8'hFF);
    repeat (2) @(negedge clk);
    chk("t4_in_bus", m_wb_stb_o, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t4_stb", m_wb_stb_o, 0);
    chk("t4_adr", m_wb_adr_o, 0);
    chk("t4_count", count, 0);
    chk("t4_ready", s_cmd_ready, 1);
    repeat (4) begin
      chk("t4_no_rsp", m_rsp_valid, 0);
      @(negedge clk);
    end
    ack_wait = 0;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Slave never acks: abort after TMO strobe cycles, then a normal transfer.
    nr       = rsp_log.size();
    ack_wait = -1;
    issue(1'b1, 37'h50, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wait_rsp(nr + 1, LIMIT);
    chk("t5_err", dut_err, 1);
    chk("t5_dat", dut_dat, 0);
    chk("t5_stb_len", last_stb_len, TMO);
    ack_wait = 0;
    dat_mode = 1;
    rd_fixed = 64'h0BAD_F00D_1234_5678;
    issue(1'b0, 37'h58, 64'h0, 8'hFF);
    wait_rsp(nr + 2, LIMIT);
    chk("t5_follow_err", dut_err, 0);
    chk("t5_follow_dat", dut_dat, 64'h0BADF00D12345678);
    dat_mode = 0;
`endif

    // 256 back-to-back reads, ack in the first strobe cycle, ready always high.
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    dat_mode  = 2;
    ack_wait  = 0;
    rdy_fixed = 1'b1;
    nr        = rsp_log.size();
    ab        = accept_cyc.size();
    for (int i = 0; i < 256; i++) issue(1'b0, 37'(i * 8), 64'h0, 8'hFF);
    wait_rsp(nr + 256, 2000);
    chk("b2b_count", count, 256);
    chk("b2b_spacing", accept_cyc[ab + 255] - accept_cyc[ab], 765);
    for (int i = 0; i < 256; i++)
      chk("b2b_dat", rsp_log[nr + i].dat, B2B_BASE | 64'(i * 8));

    // Random traffic: random commands, wait states, stray acks and response back-pressure.
    dat_mode = 0;
    ack_wait = -2;
    spurious = 1'b1;
    rand_rdy = 1'b1;
    nr       = rsp_log.size();
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 37'({$urandom, $urandom}), {$urandom, $urandom},
            8'($urandom));
    end
    rand_rdy  = 1'b0;
    rdy_fixed = 1'b1;
    wait_rsp(nr + 200, 2000);
    spurious = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
